// File: rtl/and_gate_if.sv
// and_gate_if: operand/result bundle for and_gate.
//   Parameters: WIDTH (operand/result width), CNT_W (hit counter width).
//   Signals:
//     in_valid, a, b                      driven by the master (producer)
//     y, out_valid, y_q, y_all_q,
//     y_any_q, hit_cnt                    driven by the slave (and_gate)
//   Modports: master (producer/consumer side), slave (the and_gate cell).
interface and_gate_if #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic [WIDTH-1:0] y_q;
  logic             y_all_q;
  logic             y_any_q;
  logic [CNT_W-1:0] hit_cnt;

  modport master (
    output in_valid, a, b,
    input  y, out_valid, y_q, y_all_q, y_any_q, hit_cnt
  );

  modport slave (
    input  in_valid, a, b,
    output y, out_valid, y_q, y_all_q, y_any_q, hit_cnt
  );
endinterface

// File: rtl/and_gate.sv
// and_gate: parameterised bitwise AND with a combinational result, a
// one-cycle registered copy with valid flag, registered all/any reduction
// flags and an optional saturating hit counter.
//   Parameters: WIDTH (>=1) operand width, CNT_W (>=1) hit counter width;
//               must match the parameters of the connected interface.
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous, active-high reset
//     bus   and_gate_if.slave: in_valid/a/b in; y (a & b, combinational),
//           out_valid, y_q, y_all_q, y_any_q, hit_cnt out.
//   Build option: define AND_GATE_STATS_EN to enable the hit counter, which
//   counts accepted all-ones results and saturates at its maximum. Without
//   it, hit_cnt is tied to zero.
module and_gate #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  and_gate_if.slave  bus
);

  logic [WIDTH-1:0] res;
  logic             res_all;
  logic             res_any;

  logic             out_valid;
  logic [WIDTH-1:0] y_q;
  logic             y_all_q;
  logic             y_any_q;
  logic [CNT_W-1:0] hit_cnt;

  always_comb begin
    res     = bus.a & bus.b;
    res_all = &res;
    res_any = |res;
  end

  // Result registers hold while in_valid is low; only out_valid drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      y_q       <= '0;
      y_all_q   <= 1'b0;
      y_any_q   <= 1'b0;
    end else if (bus.in_valid) begin
      out_valid <= 1'b1;
      y_q       <= res;
      y_all_q   <= res_all;
      y_any_q   <= res_any;
    end else begin
      out_valid <= 1'b0;
    end
  end

`ifdef AND_GATE_STATS_EN
  // Saturating count of accepted all-ones results.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt <= '0;
    end else if (bus.in_valid && res_all && (hit_cnt != '1)) begin
      hit_cnt <= hit_cnt + 1'b1;
    end
  end
`else
  assign hit_cnt = '0;
`endif

  assign bus.y         = res;
  assign bus.out_valid = out_valid;
  assign bus.y_q       = y_q;
  assign bus.y_all_q   = y_all_q;
  assign bus.y_any_q   = y_any_q;
  assign bus.hit_cnt   = hit_cnt;

endmodule

// File: tb/tb_and_gate.sv
// tb_and_gate: directed checks of and_gate at WIDTH=1 (CNT_W=8) and
// WIDTH=8 (CNT_W=2). Expected hit counts follow AND_GATE_STATS_EN.
module tb_and_gate;

`ifdef AND_GATE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk;
  logic rst;

  int unsigned n_vec;
  int unsigned n_err;

  and_gate_if #(.WIDTH(1), .CNT_W(8)) bus1 ();
  and_gate_if #(.WIDTH(8), .CNT_W(2)) bus8 ();

  and_gate #(.WIDTH(1), .CNT_W(8)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  and_gate #(.WIDTH(8), .CNT_W(2)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    logic       ov;
    logic [7:0] yq;
    logic       all;
    logic       any;
    logic [1:0] hit;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] hexp(input logic [1:0] x);
    return STATS ? x : 2'd0;
  endfunction

  task automatic check_reg8(input string tag, input logic ov, input logic [7:0] yq,
                            input logic all, input logic any, input logic [1:0] hit);
    check({tag, ".out_valid"}, 32'(bus8.out_valid), 32'(ov));
    check({tag, ".y_q"},       32'(bus8.y_q),       32'(yq));
    check({tag, ".y_all_q"},   32'(bus8.y_all_q),   32'(all));
    check({tag, ".y_any_q"},   32'(bus8.y_any_q),   32'(any));
    check({tag, ".hit_cnt"},   32'(bus8.hit_cnt),   32'(hit));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus1.in_valid = 1'b0; bus1.a = 1'b0; bus1.b = 1'b0;
    bus8.in_valid = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF;

    //   v  a      b      y      ov  yq     all  any  hit
    tbl[0] = '{1'b1, 8'hF0, 8'h3C, 8'h30, 1'b1, 8'h30, 1'b0, 1'b1, hexp(2'd0)};
    tbl[1] = '{1'b0, 8'hFF, 8'hFF, 8'hFF, 1'b0, 8'h30, 1'b0, 1'b1, hexp(2'd0)};
    tbl[2] = '{1'b1, 8'hAA, 8'h55, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, hexp(2'd0)};
    tbl[3] = '{1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b1, hexp(2'd1)};
    tbl[4] = '{1'b0, 8'h00, 8'h12, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b1, hexp(2'd1)};
    tbl[5] = '{1'b1, 8'h81, 8'hC3, 8'h81, 1'b1, 8'h81, 1'b0, 1'b1, hexp(2'd1)};
    tbl[6] = '{1'b1, 8'h0F, 8'hF1, 8'h01, 1'b1, 8'h01, 1'b0, 1'b1, hexp(2'd1)};

    // WIDTH=1 combinational truth table, no dependence on the clock.
    #1;
    bus1.a = 1'b0; bus1.b = 1'b0; #1; check("w1.y 00", 32'(bus1.y), 32'd0); #4;
    bus1.a = 1'b1; bus1.b = 1'b0; #1; check("w1.y 10", 32'(bus1.y), 32'd0); #4;
    bus1.a = 1'b0; bus1.b = 1'b1; #1; check("w1.y 01", 32'(bus1.y), 32'd0); #4;
    bus1.a = 1'b1; bus1.b = 1'b1; #1; check("w1.y 11", 32'(bus1.y), 32'd1); #4;

    // Reset held two cycles with valid all-ones input.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check_reg8($sformatf("rst%0d", i), 1'b0, 8'h00, 1'b0, 1'b0, 2'd0);
      check($sformatf("rst%0d.y", i), 32'(bus8.y), 32'hFF);
    end

    @(negedge clk);
    rst = 1'b0;

    // Table-driven registered path.
    for (int i = 0; i < 7; i++) begin
      bus8.in_valid = tbl[i].v;
      bus8.a = tbl[i].a;
      bus8.b = tbl[i].b;
      #1;
      check($sformatf("tbl%0d.y", i), 32'(bus8.y), 32'(tbl[i].y));
      @(posedge clk); #1;
      check_reg8($sformatf("tbl%0d", i), tbl[i].ov, tbl[i].yq, tbl[i].all, tbl[i].any, tbl[i].hit);
      @(negedge clk);
    end

    // WIDTH=1 registered: y_q, y_all_q, y_any_q track each other.
    bus1.in_valid = 1'b1; bus1.a = 1'b1; bus1.b = 1'b1;
    @(posedge clk); #1;
    check("w1.y_q 11",     32'(bus1.y_q),     32'd1);
    check("w1.y_all_q 11", 32'(bus1.y_all_q), 32'd1);
    check("w1.y_any_q 11", 32'(bus1.y_any_q), 32'd1);
    @(negedge clk);
    bus1.b = 1'b0;
    @(posedge clk); #1;
    check("w1.y_q 10",     32'(bus1.y_q),     32'd0);
    check("w1.y_all_q 10", 32'(bus1.y_all_q), 32'd0);
    check("w1.y_any_q 10", 32'(bus1.y_any_q), 32'd0);
    @(negedge clk);
    bus1.in_valid = 1'b0;

    // Reset wins over in_valid: in-flight sample dropped.
    bus8.in_valid = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reg8("midrst", 1'b0, 8'h00, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    rst = 1'b0;

    // Saturating hit counter at CNT_W=2.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("sat%0d.hit_cnt", i), 32'(bus8.hit_cnt),
            32'(hexp((i < 3) ? 2'(i + 1) : 2'd3)));
      check($sformatf("sat%0d.y_all_q", i), 32'(bus8.y_all_q), 32'd1);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("satrst.hit_cnt", 32'(bus8.hit_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus8.in_valid = 1'b0;
    @(posedge clk); #1;
    check("idle.out_valid", 32'(bus8.out_valid), 32'd0);
    check("idle.hit_cnt",   32'(bus8.hit_cnt),   32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
